cv32e40x_obi_instr_responder: RTL and testbench
===============================================

// Module: cv32e40x_obi_instr_responder
// PURPOSE
//  Behavioural OBI instruction-side responder (memory end of the fetch OBI bus) for core benches.
//  Accepts address phases, queues up to MAX_OUTSTANDING transactions and returns them in order
//  after a programmable latency. Read data comes from an internal word array.
//  Supports grant/response stalls and per-transaction error injection for fetch/RVFI checking.
// PARAMETERS
//  MEM_WORDS        1024  words in backing array; byte address range 0 .. 4*MEM_WORDS-1
//  MAX_OUTSTANDING  2     response queue depth (power of 2, >=1)
//  RESP_LATENCY     1     min cycles from address acceptance to rvalid (>=1)
// PORTS
//  clk              in   1   clock
//  rst_n            in   1   asynchronous active-low reset
//  instr_req_i      in   1   OBI address-phase request
//  instr_gnt_o      out  1   OBI grant
//  instr_addr_i     in   32  OBI address; [1:0] ignored (word fetch)
//  instr_rvalid_o   out  1   OBI response valid
//  instr_rdata_o    out  32  OBI read data
//  instr_err_o      out  1   OBI bus error
//  gnt_stall_i      in   1   force instr_gnt_o low this cycle
//  resp_stall_i     in   1   hold back instr_rvalid_o this cycle
//  err_inject_i     in   1   mark transaction accepted this cycle as error
//  load_we_i        in   1   bench write into backing array
//  load_addr_i      in   32  byte address of bench write ([1:0] ignored)
//  load_data_i      in   32  bench write data
//  outstanding_o    out  $clog2(MAX_OUTSTANDING)+1  accepted-but-unanswered count
// BEHAVIOUR
//  Reset: queue empty, outstanding_o=0, instr_gnt_o=0, instr_rvalid_o=0, instr_rdata_o=0,
//   instr_err_o=0. Array contents not reset. Reset mid-transaction drops all queued entries.
//   No response is issued for them after reset release.
//  Grant: instr_gnt_o = !full && !gnt_stall_i (comb.). Grant may be high without req.
//   full means count==MAX_OUTSTANDING; a pop in the same cycle does not free a slot.
//  Accept: instr_req_i && instr_gnt_o. Push {word index = addr[31:2], err}.
//   err = err_inject_i || (addr >= 4*MEM_WORDS). Entry age starts at 0.
//  Age: each cycle every valid entry's age increments, saturating at RESP_LATENCY.
//   Width $clog2(RESP_LATENCY+1).
//  Response: head entry only (strict in-order).
//   instr_rvalid_o = head valid && head age==RESP_LATENCY && !resp_stall_i (comb.).
//   So a transaction accepted in cycle N earliest responds in cycle N+RESP_LATENCY; never N.
//   OBI has no rready: rvalid cycle = pop.
//  Data: on rvalid, rdata = err ? 32'h0 : mem[head index]; instr_err_o = head err.
//   When rvalid=0: rdata=0, err=0.
//  Load: load_we_i writes mem[load_addr_i[31:2]] at clock edge; out-of-range writes ignored.
//   Read in same cycle as write to same word returns OLD data.
//  Count: outstanding_o = count; push+pop in same cycle leaves count unchanged.
//   Never exceeds MAX_OUTSTANDING and never underflows; assertions on both.
//  Pointers: rd/wr pointers PTR_WIDTH=$clog2(MAX_OUTSTANDING) bits, wrap modulo depth.
// TESTING
//  1 Preload mem[0]=32'h0000_0013, mem[1]=32'h0010_0093; LAT=1; req addr 0 then 4 back-to-back
//    -> gnt both cycles; rvalid cycles N+1,N+2 with rdata 0x00000013, 0x00100093; err=0.
//  2 LAT=1, depth 2, req held high with resp_stall_i=1 for 5 cycles
//    -> gnt drops after 2 accepts, outstanding_o=2; release stall -> 2 in-order responses,
//       then gnt returns.
//  3 Req addr 0x8 with err_inject_i=1, then addr 0xC clean
//    -> first rvalid: err=1, rdata=0; second: err=0, rdata=mem[3].
//  4 Req addr 4*MEM_WORDS (0x1000 for default) -> rvalid with err=1, rdata=0; no array access.
//  5 LAT=3: accept at cycle 10 -> rvalid exactly at cycle 13.
//    gnt_stall_i=1 with req high -> no accept, count unchanged.
//  6 2 outstanding, assert rst_n=0 mid-flight, release -> no rvalid ever for dropped entries;
//    outstanding_o=0; gnt=1 next cycle. Same-cycle load+response on word 5 -> old data.

Source files
------------

// File: rtl/cv32e40x_obi_instr_responder.sv
// Memory end of an OBI fetch bus: in-order responses, RESP_LATENCY cycles after accept at the earliest.
// Backpressure: gnt drops when MAX_OUTSTANDING are queued or gnt_stall_i; resp_stall_i holds the head back.
module cv32e40x_obi_instr_responder #(
  parameter int MEM_WORDS       = 1024,
  parameter int MAX_OUTSTANDING = 2,
  parameter int RESP_LATENCY    = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               instr_req_i,
  output logic                               instr_gnt_o,
  input  logic [31:0]                        instr_addr_i,
  output logic                               instr_rvalid_o,
  output logic [31:0]                        instr_rdata_o,
  output logic                               instr_err_o,
  input  logic                               gnt_stall_i,
  input  logic                               resp_stall_i,
  input  logic                               err_inject_i,
  input  logic                               load_we_i,
  input  logic [31:0]                        load_addr_i,
  input  logic [31:0]                        load_data_i,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o
);

  localparam int PTR_WIDTH = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING) + 1;
  localparam int AGE_WIDTH = $clog2(RESP_LATENCY + 1);
  localparam int IDX_WIDTH = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  localparam logic [CNT_WIDTH-1:0] DEPTH     = CNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [AGE_WIDTH-1:0] AGE_MAX   = AGE_WIDTH'(RESP_LATENCY);
  localparam logic [AGE_WIDTH-1:0] AGE_FIRST = AGE_WIDTH'(1);
  localparam logic [PTR_WIDTH-1:0] PTR_LAST  = PTR_WIDTH'(MAX_OUTSTANDING - 1);
  localparam logic [29:0]          WORDS_30  = 30'(MEM_WORDS);

  logic [31:0]          mem [MEM_WORDS];

  logic [IDX_WIDTH-1:0] idx_q [MAX_OUTSTANDING];
  logic [IDX_WIDTH-1:0] idx_d [MAX_OUTSTANDING];
  logic [AGE_WIDTH-1:0] age_q [MAX_OUTSTANDING];
  logic [AGE_WIDTH-1:0] age_d [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] err_q, err_d;
  logic [MAX_OUTSTANDING-1:0] vld_q, vld_d;
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  logic full;
  logic push;
  logic pop;
  logic head_ready;
  logic req_oob;
  logic load_in_range;
  logic unused_addr_bits;

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // A pop in the same cycle does not free a slot: gnt depends on the registered count only.
  assign full          = (count_q == DEPTH);
  assign instr_gnt_o   = rst_n && !full && !gnt_stall_i;
  assign push          = instr_req_i && instr_gnt_o;
  assign req_oob       = (instr_addr_i[31:2] >= WORDS_30);
  assign load_in_range = (load_addr_i[31:2] < WORDS_30);

  assign head_ready     = vld_q[rd_ptr_q] && (age_q[rd_ptr_q] == AGE_MAX);
  assign pop            = head_ready && !resp_stall_i;
  assign instr_rvalid_o = pop;
  assign instr_err_o    = pop && err_q[rd_ptr_q];
  assign outstanding_o  = count_q;

  assign unused_addr_bits = ^{instr_addr_i[1:0], load_addr_i[1:0]};

  // Error entries never touch the array, so an out-of-range index is never read.
  always_comb begin
    instr_rdata_o = 32'h0;
    if (pop && !err_q[rd_ptr_q]) begin
      instr_rdata_o = mem[idx_q[rd_ptr_q]];
    end
  end

  always_comb begin
    idx_d    = idx_q;
    err_d    = err_q;
    vld_d    = vld_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      age_d[i] = age_q[i];
      if (vld_q[i] && (age_q[i] != AGE_MAX)) begin
        age_d[i] = age_q[i] + 1'b1;
      end
    end

    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = ptr_inc(rd_ptr_q);
    end

    // Stored age already counts the accept cycle, so latency 1 answers on the next cycle.
    if (push) begin
      vld_d[wr_ptr_q] = 1'b1;
      idx_d[wr_ptr_q] = instr_addr_i[IDX_WIDTH+1:2];
      err_d[wr_ptr_q] = err_inject_i || req_oob;
      age_d[wr_ptr_q] = AGE_FIRST;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        idx_q[i] <= '0;
        age_q[i] <= '0;
      end
      err_q    <= '0;
      vld_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      idx_q    <= idx_d;
      age_q    <= age_d;
      err_q    <= err_d;
      vld_q    <= vld_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Backing array is deliberately not reset; a same-cycle read sees the old word.
  always_ff @(posedge clk) begin
    if (load_we_i && load_in_range) begin
      mem[load_addr_i[IDX_WIDTH+1:2]] <= load_data_i;
    end
  end

  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) count_q <= DEPTH);
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) pop |-> (count_q != '0));
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) push |-> !full);

endmodule

// File: tb/tb_cv32e40x_obi_instr_responder.sv
// Bench for the OBI instruction responder: scoreboarded data checks plus timed hand sequences.
// A second instance with RESP_LATENCY=3 covers the latency and grant-stall corners.
module tb_cv32e40x_obi_instr_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req, gnt, rvalid, err, gnt_stall, resp_stall, err_inj, load_we;
  logic [31:0] addr, rdata, load_addr, load_data;
  logic [1:0]  outstanding;

  logic        r3_req, r3_gnt, r3_rvalid, r3_err, r3_gnt_stall, r3_load_we;
  logic [31:0] r3_addr, r3_rdata, r3_load_addr, r3_load_data;
  logic [1:0]  r3_outstanding;

  cv32e40x_obi_instr_responder u_dut (
    .clk(clk), .rst_n(rst_n),
    .instr_req_i(req), .instr_gnt_o(gnt), .instr_addr_i(addr),
    .instr_rvalid_o(rvalid), .instr_rdata_o(rdata), .instr_err_o(err),
    .gnt_stall_i(gnt_stall), .resp_stall_i(resp_stall), .err_inject_i(err_inj),
    .load_we_i(load_we), .load_addr_i(load_addr), .load_data_i(load_data),
    .outstanding_o(outstanding)
  );

  cv32e40x_obi_instr_responder #(.RESP_LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .instr_req_i(r3_req), .instr_gnt_o(r3_gnt), .instr_addr_i(r3_addr),
    .instr_rvalid_o(r3_rvalid), .instr_rdata_o(r3_rdata), .instr_err_o(r3_err),
    .gnt_stall_i(r3_gnt_stall), .resp_stall_i(1'b0), .err_inject_i(1'b0),
    .load_we_i(r3_load_we), .load_addr_i(r3_load_addr), .load_data_i(r3_load_data),
    .outstanding_o(r3_outstanding)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        inj;
    logic [31:0] data;
    logic        err;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[9];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_we = 1'b1; load_addr = a; load_data = d;
    step();
    load_we = 1'b0;
  endtask

  // Holds req until granted (bounded); the expected response is queued at the accepting cycle.
  task automatic do_req(input logic [31:0] a, input logic inj, input logic [31:0] d, input logic e);
    bit done;
    done = 1'b0;
    req = 1'b1; addr = a; err_inj = inj;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (gnt) begin
        sb.push_back('{data: d, err: e});
        done = 1'b1;
      end
      step();
    end
    if (!done) check("req_grant_timeout", 32'(done), 32'h1);
    req = 1'b0; err_inj = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    check("sb_drained", 32'(sb.size()), 32'h0);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rvalid) begin
        if (sb.size() == 0) begin
          check("unexpected_rvalid", 32'(rvalid), 32'h0);
        end else begin
          mon_e = sb.pop_front();
          check("rdata", rdata, mon_e.data);
          check("rerr", 32'(err), 32'(mon_e.err));
        end
      end else begin
        check("idle_outputs", rdata | 32'(err), 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int acc;
    vecs[0] = '{32'h0000_0008, 1'b1, 32'h0,          1'b1};
    vecs[1] = '{32'h0000_000C, 1'b0, 32'hA000_0003,  1'b0};
    vecs[2] = '{32'h0000_1000, 1'b0, 32'h0,          1'b1};
    vecs[3] = '{32'h0000_0FFC, 1'b0, 32'hDEAD_BEEF,  1'b0};
    vecs[4] = '{32'h0000_0000, 1'b0, 32'h0000_0013,  1'b0};
    vecs[5] = '{32'h0000_0017, 1'b0, 32'hA000_0005,  1'b0};
    vecs[6] = '{32'hFFFF_FFFC, 1'b0, 32'h0,          1'b1};
    vecs[7] = '{32'h0000_0004, 1'b1, 32'h0,          1'b1};
    vecs[8] = '{32'h0000_0010, 1'b0, 32'hA000_0004,  1'b0};

    rst_n = 1'b0; req = 1'b0; addr = '0; gnt_stall = 1'b0; resp_stall = 1'b0; err_inj = 1'b0;
    load_we = 1'b0; load_addr = '0; load_data = '0;
    r3_req = 1'b0; r3_addr = '0; r3_gnt_stall = 1'b0;
    r3_load_we = 1'b0; r3_load_addr = '0; r3_load_data = '0;

    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_outstanding", 32'(outstanding), 32'h0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("gnt_without_req", 32'(gnt), 32'h1);
    step();

    r3_load_we = 1'b1; r3_load_addr = 32'h8; r3_load_data = 32'hC0DE_0002;
    load(32'h0, 32'h0000_0013);
    r3_load_we = 1'b0;
    load(32'h4, 32'h0010_0093);
    for (int w = 2; w < 6; w++) load(32'(4 * w), 32'hA000_0000 + 32'(w));
    load(32'h0FFC, 32'hDEAD_BEEF);
    load(32'h1000, 32'h1234_5678);

    // Back-to-back fetch of words 0 and 1 with latency 1.
    req = 1'b1; addr = 32'h0;
    @(negedge clk);
    check("t1_gnt_a", 32'(gnt), 32'h1);
    if (gnt) sb.push_back('{data: 32'h0000_0013, err: 1'b0});
    step();
    addr = 32'h4;
    @(negedge clk);
    check("t1_gnt_b", 32'(gnt), 32'h1);
    check("t1_rvalid_n1", 32'(rvalid), 32'h1);
    if (gnt) sb.push_back('{data: 32'h0010_0093, err: 1'b0});
    step();
    req = 1'b0;
    @(negedge clk);
    check("t1_rvalid_n2", 32'(rvalid), 32'h1);
    step();
    @(negedge clk);
    check("t1_rvalid_n3", 32'(rvalid), 32'h0);
    step();

    // Response stall fills the queue; grant drops at depth and returns only after pops.
    resp_stall = 1'b1; req = 1'b1; acc = 0;
    for (int c = 0; c < 5; c++) begin
      addr = 32'(8 + 4 * acc);
      @(negedge clk);
      check("t2_gnt", 32'(gnt), 32'(c < 2));
      check("t2_rvalid_stalled", 32'(rvalid), 32'h0);
      if (gnt) begin
        sb.push_back('{data: 32'hA000_0002 + 32'(acc), err: 1'b0});
        acc++;
      end
      step();
    end
    check("t2_outstanding_full", 32'(outstanding), 32'h2);
    req = 1'b0; resp_stall = 1'b0;
    @(negedge clk);
    check("t2_rv_first", 32'(rvalid), 32'h1);
    check("t2_gnt_pop_not_freed", 32'(gnt), 32'h0);
    step();
    @(negedge clk);
    check("t2_rv_second", 32'(rvalid), 32'h1);
    check("t2_gnt_back", 32'(gnt), 32'h1);
    step();
    @(negedge clk);
    check("t2_rv_done", 32'(rvalid), 32'h0);
    check("t2_outstanding_empty", 32'(outstanding), 32'h0);
    step();

    for (int i = 0; i < 9; i++) do_req(vecs[i].addr, vecs[i].inj, vecs[i].data, vecs[i].err);
    drain();

    // Latency 3: accept in cycle N answers exactly in N+3; gnt_stall blocks accepts meanwhile.
    r3_req = 1'b1; r3_addr = 32'h8;
    @(negedge clk);
    check("t5_gnt", 32'(r3_gnt), 32'h1);
    step();
    r3_gnt_stall = 1'b1;
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      check("t5_gnt_stalled", 32'(r3_gnt), 32'h0);
      check("t5_count_held", 32'(r3_outstanding), 32'h1);
      check("t5_rvalid_early", 32'(r3_rvalid), 32'h0);
      step();
    end
    r3_req = 1'b0; r3_gnt_stall = 1'b0;
    @(negedge clk);
    check("t5_rvalid_n3", 32'(r3_rvalid), 32'h1);
    check("t5_rdata", r3_rdata, 32'hC0DE_0002);
    check("t5_err", 32'(r3_err), 32'h0);
    step();
    @(negedge clk);
    check("t5_rvalid_n4", 32'(r3_rvalid), 32'h0);
    check("t5_count_zero", 32'(r3_outstanding), 32'h0);
    step();

    // Reset with two entries in flight: they must vanish.
    resp_stall = 1'b1;
    do_req(32'h0, 1'b0, 32'h0000_0013, 1'b0);
    do_req(32'h4, 1'b0, 32'h0010_0093, 1'b0);
    check("t6_outstanding_pre", 32'(outstanding), 32'h2);
    sb.delete();
    rst_n = 1'b0; resp_stall = 1'b0;
    @(negedge clk);
    check("t6_rst_outstanding", 32'(outstanding), 32'h0);
    check("t6_rst_gnt", 32'(gnt), 32'h0);
    check("t6_rst_rvalid", 32'(rvalid), 32'h0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_gnt_after_rst", 32'(gnt), 32'h1);
    step();
    repeat (4) step();
    check("t6_outstanding_post", 32'(outstanding), 32'h0);

    // Load and response to word 5 in the same cycle: old data is returned.
    req = 1'b1; addr = 32'h14;
    @(negedge clk);
    check("t6_gnt_w5", 32'(gnt), 32'h1);
    if (gnt) sb.push_back('{data: 32'hA000_0005, err: 1'b0});
    step();
    req = 1'b0;
    load_we = 1'b1; load_addr = 32'h14; load_data = 32'h5555_5555;
    @(negedge clk);
    check("t6_rvalid_w5", 32'(rvalid), 32'h1);
    step();
    load_we = 1'b0;
    do_req(32'h14, 1'b0, 32'h5555_5555, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
